vpifo_req_scheduler: RTL and testbench
======================================

// Module: vpifo_req_scheduler
// PURPOSE
//  Multi-port front end for the shared virtual-PIFO SRAM core. Buffers push/pop requests from N_PORT
//  clients in per-port task FIFOs and issues at most one op per cycle to the core, chosen round-robin.
//  Tracks per-tree occupancy: pushes to a full tree stall, and pops to an empty tree retire as null responses.
//  Routes pop data back to the issuing port in per-port request order.
// PARAMETERS
//  PTW          16   priority/data width
//  TREE_NUM     8    number of virtual trees; TIDW = $clog2(TREE_NUM)
//  LEVEL        8    core tree depth; TREE_CAP = 2**(LEVEL+1)-2 entries per tree
//  N_PORT       8    client ports; PW = $clog2(N_PORT)
//  FIFO_DEPTH   16   task FIFO entries per port (power of 2)
//  CORE_POP_LAT 2    cycles from o_core_pop high to i_core_pop_data valid
// PORTS
//  i_clk             in   1            clock
//  i_rst             in   1            synchronous reset, active high
//  i_req_valid       in   N_PORT       request strobe per port
//  i_req_pop         in   N_PORT       1 = pop, 0 = push
//  i_req_tree        in   N_PORT*TIDW  target tree per port
//  i_req_data        in   N_PORT*PTW   push data per port (ignored for pop)
//  o_fifo_full       out  N_PORT       task FIFO full
//  o_overflow        out  N_PORT       sticky: request dropped while full
//  o_rsp_valid       out  N_PORT       pop response for port p
//  o_rsp_empty       out  1            response is null (tree was empty)
//  o_rsp_data        out  PTW          pop data (0 when o_rsp_empty)
//  o_core_push       out  1            push to core
//  o_core_pop        out  1            pop from core
//  o_core_tree_id    out  TIDW         core tree select
//  o_core_push_data  out  PTW          core push data
//  i_core_pop_data   in   PTW          core pop data, CORE_POP_LAT after o_core_pop
// BEHAVIOUR
//  - Reset: all FIFOs empty; occ[*]=0; rr pointer=0; delay line cleared; every output 0.
//    Reset mid-operation discards queued and in-flight ops. The core is reset in the same cycle.
//  - Enqueue: i_req_valid[p] && !o_fifo_full[p] -> entry {pop,tree,data} written at the clock edge.
//    If o_fifo_full[p] is high, the request is dropped and o_overflow[p] is set (cleared only by reset).
//    o_fifo_full reflects the registered count. Enqueue into an empty FIFO is eligible next cycle.
//  - Eligibility of a head: push -> occ[tree] < TREE_CAP; pop -> always eligible.
//    An ineligible head blocks its own port only; no reordering within a port.
//  - Arbitration: each cycle, grant the first eligible port at or after rr (wrapping). Then rr = grant+1 mod N_PORT.
//    With no eligible port, rr is held and no op is issued.
//  - Issue (registered, 1 cycle after grant): head dequeued in the grant cycle.
//    Push: o_core_push=1, occ[tree]++. Pop with occ[tree]>0: o_core_pop=1, occ[tree]--.
//    Pop with occ[tree]==0: no core op; a null token is inserted into the delay line.
//    occ updates at grant, so back-to-back ops to the same tree see the correct count. One op per cycle means no occ conflicts.
//    Simultaneous enqueue and dequeue on the same FIFO are legal; count is unchanged.
//  - Response: delay line of CORE_POP_LAT+1 stages carries {valid,port,empty}, one slot per issue.
//    At the tail: o_rsp_valid[port]=1 for one cycle; o_rsp_data = empty ? 0 : i_core_pop_data.
//    Null and real pops have identical latency (grant to rsp = CORE_POP_LAT+2), so per-port response order equals request order.
//  - occ width $clog2(TREE_CAP+1). It never wraps (guarded by eligibility). FIFO pointers wrap mod FIFO_DEPTH.
// STRUCTURE
//  - vpifo_pkg: typedef struct packed {logic pop; logic [TIDW-1:0] tree; logic [PTW-1:0] data;} task_t;
//    rsp_tok_t {valid,port,empty}; function tree_cap(LEVEL).
//  - Sub-module vpifo_task_fifo (one per port, generate loop): depth FIFO_DEPTH, task_t payload, full/empty/count.
//  - Top holds the RR arbiter, occ[TREE_NUM] array, issue registers and response delay line.
// TESTING
//  1 Reset: hold i_rst 3 cycles mid-traffic -> all outputs 0, occ=0; next request processed normally.
//  2 Fill: port0 pushes tree0 data 0..509 (TREE_CAP=510) -> 510 core pushes; the 511th push stalls the port0 head.
//    A port1 pop on tree0 issues -> the stalled push then issues.
//  3 Null pop: pop tree3 from reset -> no o_core_pop; o_rsp_valid[0]=1, o_rsp_empty=1, data 0, CORE_POP_LAT+2 cycles after grant.
//  4 Fairness: all 8 ports push continuously, trees=port id -> grants cycle 0,1,..,7,0 with one issue per cycle.
//  5 Overflow: stall port2 (tree full) and send 17 requests -> o_fifo_full after 16; the 17th is dropped and o_overflow[2]=1.
//  6 Ordering: port4 pops tree5 (occ 1) then pops tree6 (occ 0) -> real response, then null response, in order.
//    Results are checked against a scoreboard model.

Source files
------------

// File: rtl/vpifo_pkg.sv
// Shared types and geometry for the virtual-PIFO request scheduler.
package vpifo_pkg;
  localparam int PTW      = 16;
  localparam int TREE_NUM = 8;
  localparam int TIDW     = $clog2(TREE_NUM);
  localparam int LEVEL    = 8;
  localparam int N_PORT   = 8;
  localparam int PW       = $clog2(N_PORT);

  function automatic int tree_cap(input int level);
    return (1 << (level + 1)) - 2;
  endfunction

  localparam int TREE_CAP = tree_cap(LEVEL);
  localparam int OCCW     = $clog2(TREE_CAP + 1);

  typedef struct packed {
    logic            pop;
    logic [TIDW-1:0] tree;
    logic [PTW-1:0]  data;
  } task_t;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] port;
    logic          empty;
  } rsp_tok_t;
endpackage

// File: rtl/vpifo_task_fifo.sv
// Per-port task FIFO; head is presented combinationally from the read pointer.
module vpifo_task_fifo
  import vpifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  task_t wr_data,
  input  logic  rd_en,
  output task_t rd_data,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  task_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/vpifo_req_scheduler.sv
// Round-robin front end for the shared virtual-PIFO core: per-port task FIFOs,
// per-tree occupancy tracking and an in-order response delay line.
module vpifo_req_scheduler
  import vpifo_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CORE_POP_LAT = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_PORT-1:0]          i_req_valid,
  input  logic [N_PORT-1:0]          i_req_pop,
  input  logic [N_PORT-1:0][TIDW-1:0] i_req_tree,
  input  logic [N_PORT-1:0][PTW-1:0] i_req_data,
  output logic [N_PORT-1:0]          o_fifo_full,
  output logic [N_PORT-1:0]          o_overflow,
  output logic [N_PORT-1:0]          o_rsp_valid,
  output logic                       o_rsp_empty,
  output logic [PTW-1:0]             o_rsp_data,
  output logic                       o_core_push,
  output logic                       o_core_pop,
  output logic [TIDW-1:0]            o_core_tree_id,
  output logic [PTW-1:0]             o_core_push_data,
  input  logic [PTW-1:0]             i_core_pop_data
);
  task_t             head [N_PORT];
  task_t             g_task;
  logic [N_PORT-1:0] fifo_empty, elig, grant_oh;
  logic [OCCW-1:0]   occ [TREE_NUM];
  logic [PW-1:0]     rr, gnt, idx;
  logic              gnt_vld;
  rsp_tok_t          dly_pipe [CORE_POP_LAT+1];
  rsp_tok_t          tail;

  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    task_t wr;
    assign wr = '{pop: i_req_pop[p], tree: i_req_tree[p], data: i_req_data[p]};

    vpifo_task_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (i_clk),
      .rst    (i_rst),
      .wr_en  (i_req_valid[p] && !o_fifo_full[p]),
      .wr_data(wr),
      .rd_en  (grant_oh[p]),
      .rd_data(head[p]),
      .full   (o_fifo_full[p]),
      .empty  (fifo_empty[p])
    );

    // A push to a full tree blocks only its own port.
    assign elig[p] = !fifo_empty[p] &&
                     (head[p].pop || (occ[head[p].tree] < OCCW'(TREE_CAP)));
  end

  // Descending scan so the eligible port closest to rr wins.
  always_comb begin
    gnt     = rr;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = N_PORT - 1; i >= 0; i--) begin
      idx = rr + PW'(i);
      if (elig[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  assign grant_oh = gnt_vld ? (N_PORT'(1) << gnt) : '0;
  assign g_task   = head[gnt];
  assign tail     = dly_pipe[CORE_POP_LAT];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr               <= '0;
      o_overflow       <= '0;
      o_core_push      <= 1'b0;
      o_core_pop       <= 1'b0;
      o_core_tree_id   <= '0;
      o_core_push_data <= '0;
      o_rsp_valid      <= '0;
      o_rsp_empty      <= 1'b0;
      o_rsp_data       <= '0;
      for (int t = 0; t < TREE_NUM; t++) occ[t] <= '0;
      for (int k = 0; k <= CORE_POP_LAT; k++) dly_pipe[k] <= '0;
    end else begin
      o_overflow  <= o_overflow | (i_req_valid & o_fifo_full);
      o_core_push <= 1'b0;
      o_core_pop  <= 1'b0;
      dly_pipe[0] <= '0;
      if (gnt_vld) begin
        rr             <= gnt + 1'b1;
        o_core_tree_id <= g_task.tree;
        if (!g_task.pop) begin
          o_core_push      <= 1'b1;
          o_core_push_data <= g_task.data;
          occ[g_task.tree] <= occ[g_task.tree] + 1'b1;
        end else begin
          // Null pops still occupy a slot so per-port response order holds.
          dly_pipe[0] <= '{valid: 1'b1, port: gnt, empty: (occ[g_task.tree] == '0)};
          if (occ[g_task.tree] != '0) begin
            o_core_pop       <= 1'b1;
            occ[g_task.tree] <= occ[g_task.tree] - 1'b1;
          end
        end
      end
      for (int k = 1; k <= CORE_POP_LAT; k++) dly_pipe[k] <= dly_pipe[k-1];
      o_rsp_valid <= tail.valid ? (N_PORT'(1) << tail.port) : '0;
      o_rsp_empty <= tail.valid && tail.empty;
      o_rsp_data  <= (tail.valid && !tail.empty) ? i_core_pop_data : '0;
    end
  end
endmodule

// File: tb/tb_vpifo_req_scheduler.sv
// Directed + random bench for vpifo_req_scheduler against a queue-based transaction model.
module tb_vpifo_req_scheduler;
  localparam int NP = 8, FD = 16, CAP = 510, LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] req_valid, req_pop;
  logic [NP-1:0][2:0] req_tree;
  logic [NP-1:0][15:0] req_data;
  logic [NP-1:0] fifo_full, overflow, rsp_valid;
  logic rsp_empty, core_push, core_pop;
  logic [15:0] rsp_data, core_push_data, core_data;
  logic [2:0] core_tree_id;

  vpifo_req_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_pop(req_pop),
    .i_req_tree(req_tree), .i_req_data(req_data), .o_fifo_full(fifo_full),
    .o_overflow(overflow), .o_rsp_valid(rsp_valid), .o_rsp_empty(rsp_empty),
    .o_rsp_data(rsp_data), .o_core_push(core_push), .o_core_pop(core_pop),
    .o_core_tree_id(core_tree_id), .o_core_push_data(core_push_data),
    .i_core_pop_data(core_data)
  );

  always #5 clk = ~clk;

  typedef struct {logic pop; int tree; logic [15:0] data;} mtask_t;
  typedef struct {int cyc; int port; logic empty; logic [15:0] data;} mrsp_t;
  typedef struct {int cyc; logic [15:0] data;} mcore_t;

  mtask_t mq [NP][$];
  int occ_m [8];
  int rr_m, t;
  logic [NP-1:0] ovf_m;
  mrsp_t rsp_q[$];
  mcore_t core_q[$];
  logic exp_push, exp_pop, exp_zero;
  int exp_tree;
  logic [15:0] exp_pdata;

  int checks = 0, errors = 0;
  int n_push, n_pop, rsp_t;
  logic rsp_empty_last;
  logic [15:0] rsp_data_last;
  int iss_q[$], iss_c[$];
  logic p4_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the scheduling rules for one clock edge to the model.
  task automatic model_edge();
    logic [NP-1:0] full;
    int g, p;
    mtask_t tk;
    logic [15:0] v;
    exp_push = 1'b0; exp_pop = 1'b0; exp_zero = 1'b0;
    if (rst) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      for (int i = 0; i < 8; i++) occ_m[i] = 0;
      rr_m = 0; ovf_m = '0; exp_zero = 1'b1;
      rsp_q.delete(); core_q.delete();
      return;
    end
    for (int i = 0; i < NP; i++) full[i] = (mq[i].size() == FD);
    g = -1;
    for (int i = 0; i < NP && g < 0; i++) begin
      p = (rr_m + i) % NP;
      if (mq[p].size() > 0 && (mq[p][0].pop || occ_m[mq[p][0].tree] < CAP)) g = p;
    end
    if (g >= 0) begin
      tk = mq[g].pop_front();
      rr_m = (g + 1) % NP;
      exp_tree = tk.tree;
      if (!tk.pop) begin
        exp_push = 1'b1; exp_pdata = tk.data; occ_m[tk.tree]++;
      end else begin
        v = '0;
        if (occ_m[tk.tree] > 0) begin
          exp_pop = 1'b1; occ_m[tk.tree]--;
          v = 16'($urandom);
          core_q.push_back('{cyc: t + 1 + LAT, data: v});
        end
        rsp_q.push_back('{cyc: t + LAT + 2, port: g, empty: !exp_pop, data: v});
      end
    end
    for (int i = 0; i < NP; i++)
      if (req_valid[i]) begin
        if (full[i]) ovf_m[i] = 1'b1;
        else mq[i].push_back('{pop: req_pop[i], tree: int'(req_tree[i]), data: req_data[i]});
      end
  endtask

  task automatic check_outputs();
    logic [NP-1:0] ev, ef;
    logic ee;
    logic [15:0] ed;
    chk("core_push", 32'(core_push), 32'(exp_push));
    chk("core_pop", 32'(core_pop), 32'(exp_pop));
    if (exp_push || exp_pop) chk("core_tree", 32'(core_tree_id), 32'(exp_tree));
    if (exp_push) chk("core_pdata", 32'(core_push_data), 32'(exp_pdata));
    if (exp_zero) begin
      chk("rst_tree", 32'(core_tree_id), 32'd0);
      chk("rst_pdata", 32'(core_push_data), 32'd0);
    end
    ev = '0; ee = 1'b0; ed = '0;
    if (rsp_q.size() > 0 && rsp_q[0].cyc == t) begin
      ev[rsp_q[0].port] = 1'b1; ee = rsp_q[0].empty; ed = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_empty", 32'(rsp_empty), 32'(ee));
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    for (int i = 0; i < NP; i++) ef[i] = (mq[i].size() == FD);
    chk("fifo_full", 32'(fifo_full), 32'(ef));
    chk("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic cyc();
    core_data = 16'($urandom);
    while (core_q.size() > 0 && core_q[0].cyc < t) void'(core_q.pop_front());
    if (core_q.size() > 0 && core_q[0].cyc == t) core_data = core_q[0].data;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    t++;
    check_outputs();
    if (core_push) begin n_push++; iss_q.push_back(int'(core_tree_id)); iss_c.push_back(t); end
    if (core_pop) n_pop++;
    if (rsp_valid != '0) begin rsp_t = t; rsp_empty_last = rsp_empty; rsp_data_last = rsp_data; end
    if (rsp_valid[4]) p4_q.push_back(rsp_empty);
  endtask

  task automatic idle();
    req_valid = '0; req_pop = '0; req_tree = '0; req_data = '0;
  endtask

  task automatic reset_and_clear();
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
    n_push = 0; n_pop = 0; rsp_t = -1; iss_q.delete(); iss_c.delete(); p4_q.delete();
  endtask

  task automatic rand_traffic(input int n);
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < NP; p++) begin
        req_valid[p] = ($urandom_range(0, 3) == 0);
        req_pop[p]   = 1'($urandom_range(0, 1));
        req_tree[p]  = 3'($urandom_range(0, 7));
        req_data[p]  = 16'($urandom);
      end
      cyc();
    end
  endtask

  initial begin
    int t0;
    t = 0; rst = 1'b1; core_data = '0; idle();
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;

    // Random traffic with a 3-cycle reset in the middle of it.
    rand_traffic(300);
    rst = 1'b1; rand_traffic(3); rst = 1'b0;
    rand_traffic(100);
    idle(); repeat (40) cyc();

    // Fill tree0 to capacity; the next push stalls until a pop frees a slot.
    reset_and_clear();
    for (int i = 0; i <= CAP; i++) begin
      req_valid = 8'h01; req_pop = '0; req_tree = '0; req_data[0] = 16'(i);
      cyc();
    end
    idle(); repeat (8) cyc();
    chk("fill_pushes", 32'(n_push), 32'(CAP));
    req_valid = 8'h02; req_pop = 8'h02; cyc();
    idle(); repeat (8) cyc();
    chk("fill_pops", 32'(n_pop), 32'd1);
    chk("fill_after_pop", 32'(n_push), 32'(CAP + 1));
    chk("fill_pop_data", 32'(rsp_empty_last), 32'd0);

    // Null pop on an empty tree.
    reset_and_clear();
    req_valid = 8'h01; req_pop = 8'h01; req_tree[0] = 3'd3;
    t0 = t; cyc();
    idle(); repeat (8) cyc();
    chk("null_lat", 32'(rsp_t - t0), 32'(LAT + 3));
    chk("null_nopop", 32'(n_pop), 32'd0);
    chk("null_empty", 32'(rsp_empty_last), 32'd1);
    chk("null_data", 32'(rsp_data_last), 32'd0);

    // Fairness: every port pushes to its own tree continuously.
    reset_and_clear();
    for (int k = 0; k < 24; k++) begin
      for (int p = 0; p < NP; p++) begin
        req_valid[p] = 1'b1; req_pop[p] = 1'b0; req_tree[p] = 3'(p); req_data[p] = 16'($urandom);
      end
      cyc();
    end
    idle(); repeat (140) cyc();
    for (int i = 0; i < 16; i++) begin
      chk("fair_tree", 32'(iss_q[i]), 32'(i % NP));
      chk("fair_gap", 32'(iss_c[i] - iss_c[0]), 32'(i));
    end

    // Overflow: port2 stalled on a full tree2 receives 17 more requests.
    reset_and_clear();
    for (int i = 0; i < CAP + 17; i++) begin
      req_valid = 8'h04; req_pop = '0; req_tree[2] = 3'd2; req_data[2] = 16'(i);
      cyc();
    end
    idle(); repeat (4) cyc();
    chk("ovf_full", 32'(fifo_full), 32'h04);
    chk("ovf_sticky", 32'(overflow), 32'h04);
    chk("ovf_pushes", 32'(n_push), 32'(CAP));

    // Ordering: real pop then null pop on the same port.
    reset_and_clear();
    req_valid = 8'h01; req_pop = '0; req_tree[0] = 3'd5; req_data[0] = 16'h1234; cyc();
    idle(); repeat (3) cyc();
    req_valid = 8'h10; req_pop = 8'h10; req_tree[4] = 3'd5; cyc();
    req_tree[4] = 3'd6; cyc();
    idle(); repeat (8) cyc();
    chk("ord_count", 32'(p4_q.size()), 32'd2);
    if (p4_q.size() == 2) begin
      chk("ord_first_real", 32'(p4_q[0]), 32'd0);
      chk("ord_second_null", 32'(p4_q[1]), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
